// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch front end: datapath widths, the canonical
// NOP encoding and the fetch FSM state encodings.
package riscv_pkg;

   localparam int XLEN    = 32;
   localparam int INSTR_W = 32;

   localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

   // Encodings are visible on the debug state port, so they are fixed here.
   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_HALTED = 2'd1,
      ST_FAULT  = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous prefetch FIFO. A flush empties it in one cycle. A push
// and a pop in the same cycle are both honoured, even when the FIFO is full.
// The head word is presented raw; callers gate it with empty if needed.
module fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // Pointers wrap explicitly at DEPTH so the storage index never leaves range.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign rdata = mem[rd_ptr];
   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

   // Storage write; contents need no reset because count qualifies them.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointer and occupancy bookkeeping; reset and flush both empty the FIFO.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= next_ptr(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer. It owns the PC and reads the combinational
// instruction memory. It queues {pc, instr} pairs in a prefetch FIFO for
// decode, and handles redirects, halt and out-of-range fetch faults.
module fetch_controller
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2,
   parameter int          IMEM_WORDS = 256
) (
   input  logic                clk,
   input  logic                reset,
   output logic [XLEN-1:0]     imem_addr,
   input  logic [INSTR_W-1:0]  imem_instr,
   input  logic                redirect_valid,
   input  logic [XLEN-1:0]     redirect_pc,
   input  logic                halt,
   output logic                inst_valid,
   input  logic                inst_ready,
   output logic [INSTR_W-1:0]  inst_data,
   output logic [XLEN-1:0]     inst_pc,
   output logic                fault,
   output logic [1:0]          state
);

   localparam int              CNT_W   = $clog2(FIFO_DEPTH + 1);
   localparam int              ENTRY_W = XLEN + INSTR_W;
   localparam logic [XLEN-1:0] PC_MASK = ~32'd3;

   logic [XLEN-1:0]    fetch_pc;
   fetch_state_t       state_q;
   fetch_state_t       state_d;
   logic               fault_q;

   logic [CNT_W-1:0]   fifo_count;
   logic               fifo_full;
   logic               fifo_empty;
   logic [ENTRY_W-1:0] fifo_head;

   logic               do_pop;
   logic               room;
   logic               want_push;
   logic               do_push;
   logic               out_of_range;

   assign imem_addr  = fetch_pc;
   assign inst_valid = (fifo_count != '0);
   assign inst_pc    = fifo_empty ? '0 : fifo_head[ENTRY_W-1:INSTR_W];
   assign inst_data  = fifo_empty ? '0 : fifo_head[INSTR_W-1:0];
   assign fault      = fault_q;
   assign state      = state_q;

   // A redirect voids any handshake in its cycle because the FIFO is flushed.
   assign do_pop       = inst_valid && inst_ready && !redirect_valid;
   assign room         = !fifo_full || do_pop;
   assign out_of_range = {2'b00, fetch_pc[31:2]} >= 32'(IMEM_WORDS);
   assign want_push    = (state_q == ST_RUN) && !halt && !redirect_valid && room;
   assign do_push      = want_push && !out_of_range;

   fetch_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (redirect_valid),
      .push  (do_push),
      .pop   (do_pop),
      .wdata ({fetch_pc, imem_instr}),
      .rdata (fifo_head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Next-state logic: a redirect overrides everything but still respects halt.
   always_comb begin
      state_d = state_q;
      if (redirect_valid) begin
         state_d = halt ? ST_HALTED : ST_RUN;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (halt) begin
                  state_d = ST_HALTED;
               end else if (want_push && out_of_range) begin
                  state_d = ST_FAULT;
               end
            end
            ST_HALTED: begin
               if (!halt) begin
                  state_d = ST_RUN;
               end
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_RUN;
         endcase
      end
   end

   // PC, FSM state and sticky fault register.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc <= RESET_PC & PC_MASK;
         state_q  <= ST_RUN;
         fault_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (redirect_valid) begin
            fetch_pc <= redirect_pc & PC_MASK;
            fault_q  <= 1'b0;
         end else begin
            if (do_push) begin
               fetch_pc <= fetch_pc + 32'd4;
            end
            if (want_push && out_of_range) begin
               fault_q <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with default parameters
// (RESET_PC = 0, FIFO_DEPTH = 2, IMEM_WORDS = 256).
module tb_fetch_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        fault;
   logic [1:0]  state;

   int checks = 0;
   int errors = 0;

   fetch_controller dut (
      .clk            (clk),
      .reset          (reset),
      .imem_addr      (imem_addr),
      .imem_instr     (imem_instr),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt           (halt),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .fault          (fault),
      .state          (state)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Memory image: each word encodes its own word index, so a lost or
   // duplicated fetch shows up in the data as well as in the pc.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {2'b10, a[31:2]};
   endfunction

   assign imem_instr = mem_word(imem_addr);

   // Advance one clock and settle just after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic rst, input logic rv, input logic [31:0] rpc,
                                input logic h, input logic rdy);
      reset          = rst;
      redirect_valid = rv;
      redirect_pc    = rpc;
      halt           = h;
      inst_ready     = rdy;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic checkHead(input string tag, input logic [31:0] pc);
      checkOutput({tag, "_valid"}, {31'd0, inst_valid}, 32'd1);
      checkOutput({tag, "_pc"}, inst_pc, pc);
      checkOutput({tag, "_data"}, inst_data, mem_word(pc));
   endtask

   initial begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      step();
      step();
      checkOutput("rst_valid", {31'd0, inst_valid}, 32'd0);
      checkOutput("rst_fault", {31'd0, fault}, 32'd0);
      checkOutput("rst_state", {30'd0, state}, 32'd0);
      checkOutput("rst_addr", imem_addr, 32'h0);
      checkOutput("rst_pc", inst_pc, 32'h0);
      checkOutput("rst_data", inst_data, 32'h0);

      $display("[TB] streaming fetch");
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("t1_c0_valid", {31'd0, inst_valid}, 32'd0);
      step();
      checkHead("t1_pc0", 32'h0);
      step();
      checkHead("t1_pc4", 32'h4);
      step();
      checkHead("t1_pc8", 32'h8);
      step();
      checkHead("t1_pcC", 32'hC);

      $display("[TB] backpressure");
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      step();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step();
         checkHead("t2_hold", 32'h0);
         checkOutput("t2_addr", imem_addr, (i == 0) ? 32'h4 : 32'h8);
      end
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      step();
      checkHead("t2_rel4", 32'h4);
      step();
      checkHead("t2_rel8", 32'h8);
      step();
      checkHead("t2_relC", 32'hC);
      checkOutput("t2_full_addr", imem_addr, 32'h14);

      $display("[TB] redirect while full");
      applyStimulus(1'b0, 1'b1, 32'h23, 1'b0, 1'b1);
      step();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("t3_valid", {31'd0, inst_valid}, 32'd0);
      checkOutput("t3_addr", imem_addr, 32'h20);
      checkOutput("t3_pc_empty", inst_pc, 32'h0);
      step();
      checkHead("t3_target", 32'h20);

      $display("[TB] halt");
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      step();
      checkHead("t4_pre", 32'h20);
      checkOutput("t4_pre_addr", imem_addr, 32'h28);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      step();
      checkHead("t4_drain", 32'h24);
      checkOutput("t4_state1", {30'd0, state}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         step();
         checkOutput("t4_empty", {31'd0, inst_valid}, 32'd0);
         checkOutput("t4_frozen", imem_addr, 32'h28);
         checkOutput("t4_state", {30'd0, state}, 32'd1);
      end
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      step();
      checkOutput("t4_run", {30'd0, state}, 32'd0);
      checkOutput("t4_run_addr", imem_addr, 32'h28);
      step();
      checkHead("t4_resume", 32'h28);

      $display("[TB] fault at end of memory");
      applyStimulus(1'b0, 1'b1, 32'h3FC, 1'b0, 1'b1);
      step();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("t5_redir_valid", {31'd0, inst_valid}, 32'd0);
      checkOutput("t5_redir_addr", imem_addr, 32'h3FC);
      step();
      checkHead("t5_word255", 32'h3FC);
      checkOutput("t5_addr400", imem_addr, 32'h400);
      for (int i = 0; i < 2; i++) begin
         step();
         checkOutput("t5_valid", {31'd0, inst_valid}, 32'd0);
         checkOutput("t5_fault", {31'd0, fault}, 32'd1);
         checkOutput("t5_state", {30'd0, state}, 32'd2);
         checkOutput("t5_addr", imem_addr, 32'h400);
      end
      applyStimulus(1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
      step();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("t5_clr_fault", {31'd0, fault}, 32'd0);
      checkOutput("t5_clr_state", {30'd0, state}, 32'd0);
      checkOutput("t5_clr_addr", imem_addr, 32'h0);
      step();
      checkHead("t5_restart", 32'h0);

      $display("[TB] reset mid-stream");
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      step();
      checkHead("t6_full", 32'h0);
      checkOutput("t6_full_addr", imem_addr, 32'h8);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      step();
      checkOutput("t6_valid", {31'd0, inst_valid}, 32'd0);
      checkOutput("t6_fault", {31'd0, fault}, 32'd0);
      checkOutput("t6_addr", imem_addr, 32'h0);
      checkOutput("t6_state", {30'd0, state}, 32'd0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      step();
      checkHead("t6_pc0", 32'h0);
      step();
      checkHead("t6_pc4", 32'h4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
